// File: rtl/pipa_spoof_gen.sv
// pipa_spoof_gen: spoofs AGC PIPA accelerometer pulse trains using a moding-slot pattern
// Ports:
//   SIM_CLK    - sole clock, rising edge
//   SIM_RST_n  - asynchronous active-low reset
//   PIPASW     - async PIPA strobe; each rising edge advances the moding slot
//   PIPDAT     - async PIPA data-read window
//   CH_BIAS    - signed net pulses per cycle, channel i at [i*BW +: BW]
//   PIPAp/m    - per-channel plus/minus pulses (registered)
//   SLOT       - current moding slot
//   CYC_DONE   - one-cycle pulse when SLOT wraps to 0
//   NETCNT     - signed 16-bit net pulse accumulators per channel (PIPA_SPOOF_NETCNT_EN only)
// Optional feature macro: PIPA_SPOOF_NETCNT_EN
module pipa_spoof_gen #(
    parameter int NCHAN    = 3,
    parameter int MODE_LEN = 6,
    parameter int BW       = $clog2(MODE_LEN) + 2
) (
    input  logic                        SIM_CLK,
    input  logic                        SIM_RST_n,
    input  logic                        PIPASW,
    input  logic                        PIPDAT,
    input  logic [NCHAN*BW-1:0]         CH_BIAS,
    output logic [NCHAN-1:0]            PIPAp,
    output logic [NCHAN-1:0]            PIPAm,
    output logic [$clog2(MODE_LEN)-1:0] SLOT,
    output logic                        CYC_DONE
`ifdef PIPA_SPOOF_NETCNT_EN
    ,
    output logic [NCHAN*16-1:0]         NETCNT
`endif
);
    localparam int SW = $clog2(MODE_LEN);
    localparam logic signed [BW:0] ML = (BW+1)'(MODE_LEN);

    logic          sw_s1, sw_s2, sw_prev, sw_edge;
    logic          dat_s1, dat_s2;
    logic [1:0]    fill;
    logic [BW-1:0] plus_cnt [NCHAN];
    logic [NCHAN-1:0] plus;
    logic          wrap;

    // Clamp the bias to +/-MODE_LEN, then (MODE_LEN + bias) >>> 1; the sum is never
    // negative so dropping the low bit is the floor.
    function automatic logic [BW-1:0] plus_of(input logic signed [BW-1:0] bias);
        logic signed [BW:0] b, s;
        b = {bias[BW-1], bias};
        b = (b > ML) ? ML : (b < -ML) ? -ML : b;
        s = b + ML;
        return s[BW:1];
    endfunction

    assign wrap = sw_edge && (SLOT == SW'(MODE_LEN - 1));

    always_comb begin
        plus = '0;
        for (int i = 0; i < NCHAN; i++)
            plus[i] = BW'(SLOT) < plus_cnt[i];
    end

    // fill marks how far the synchronisers have refilled since reset: fill[0] is low only
    // on the first clock (pluscnt load), and sw_prev is held high until the synchronised
    // copy is valid so a PIPASW already high at release is not seen as an edge.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_n)
        if (!SIM_RST_n) begin
            {sw_s2, sw_s1}   <= '0;
            {dat_s2, dat_s1} <= '0;
            fill     <= '0;
            sw_prev  <= 1'b1;
            sw_edge  <= 1'b0;
            SLOT     <= '0;
            CYC_DONE <= 1'b0;
            PIPAp    <= '0;
            PIPAm    <= '0;
            for (int i = 0; i < NCHAN; i++)
                plus_cnt[i] <= '0;
        end else begin
            {sw_s2, sw_s1}   <= {sw_s1, PIPASW};
            {dat_s2, dat_s1} <= {dat_s1, PIPDAT};
            fill     <= {fill[0], 1'b1};
            sw_prev  <= fill[1] ? sw_s2 : 1'b1;
            sw_edge  <= sw_s2 & ~sw_prev;
            SLOT     <= sw_edge ? (wrap ? '0 : SLOT + 1'b1) : SLOT;
            CYC_DONE <= wrap;
            PIPAp    <= {NCHAN{dat_s2}} & plus;
            PIPAm    <= {NCHAN{dat_s2}} & ~plus;
            if (wrap || !fill[0])
                for (int i = 0; i < NCHAN; i++)
                    plus_cnt[i] <= plus_of(CH_BIAS[i*BW +: BW]);
        end

`ifdef PIPA_SPOOF_NETCNT_EN
    logic dat_prev;

    always_ff @(posedge SIM_CLK or negedge SIM_RST_n)
        if (!SIM_RST_n) begin
            dat_prev <= 1'b1;
            NETCNT   <= '0;
        end else begin
            dat_prev <= fill[1] ? dat_s2 : 1'b1;
            if (dat_s2 && !dat_prev)
                for (int i = 0; i < NCHAN; i++)
                    NETCNT[i*16 +: 16] <= NETCNT[i*16 +: 16] + (plus[i] ? 16'd1 : 16'hFFFF);
        end
`endif
endmodule

// File: tb/tb_pipa_spoof_gen.sv
// tb_pipa_spoof_gen: directed scoreboard bench for pipa_spoof_gen (NCHAN=3, MODE_LEN=6)
module tb_pipa_spoof_gen;
    localparam int NCHAN = 3;
    localparam int ML    = 6;
    localparam int BW    = $clog2(ML) + 2;

    logic clk = 1'b0, rst_n = 1'b0, sw = 1'b1, dat = 1'b0;
    logic [NCHAN*BW-1:0] bias = '0;
    logic [NCHAN-1:0] pp, pm;
    logic [$clog2(ML)-1:0] slot;
    logic cd;
`ifdef PIPA_SPOOF_NETCNT_EN
    logic [NCHAN*16-1:0] net;
`endif

    int tests = 0, fails = 0;
    logic [2*NCHAN-1:0] sbq [$];
    int bias_m [NCHAN];
    int pcm [NCHAN];
    int net_m [NCHAN];
    int sl = 0, cd_cnt = 0, cd_exp = 0;

    pipa_spoof_gen #(.NCHAN(NCHAN), .MODE_LEN(ML)) dut (
        .SIM_CLK(clk), .SIM_RST_n(rst_n), .PIPASW(sw), .PIPDAT(dat), .CH_BIAS(bias),
        .PIPAp(pp), .PIPAm(pm), .SLOT(slot), .CYC_DONE(cd)
`ifdef PIPA_SPOOF_NETCNT_EN
        , .NETCNT(net)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cd === 1'b1) cd_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pcalc(input int b);
        int c;
        c = (b > ML) ? ML : (b < -ML) ? -ML : b;
        return (ML + c) / 2;
    endfunction

    function automatic logic [2*NCHAN-1:0] exp_vec();
        logic [2*NCHAN-1:0] e;
        for (int i = 0; i < NCHAN; i++) begin
            e[i]         = sl < pcm[i];
            e[NCHAN + i] = !(sl < pcm[i]);
        end
        return e;
    endfunction

    task automatic set_bias(input int b0, input int b1, input int b2);
        bias_m = '{b0, b1, b2};
        for (int i = 0; i < NCHAN; i++) bias[i*BW +: BW] = BW'(bias_m[i]);
    endtask

    task automatic latch_model();
        for (int i = 0; i < NCHAN; i++) pcm[i] = pcalc(bias_m[i]);
    endtask

    task automatic check_net();
`ifdef PIPA_SPOOF_NETCNT_EN
        for (int i = 0; i < NCHAN; i++)
            chk($sformatf("netcnt%0d", i), {16'b0, net[i*16 +: 16]}, {16'b0, 16'(net_m[i])});
`endif
    endtask

    // One moding slot: PIPDAT window (latency and value checked), then a PIPASW strobe.
    task automatic pulse();
        logic [2*NCHAN-1:0] e;
        e = exp_vec();
        sbq.push_back(e);
        for (int i = 0; i < NCHAN; i++) net_m[i] += e[i] ? 1 : -1;
        @(negedge clk) dat = 1'b1;
        repeat (2) @(negedge clk);
        chk("lat2", {pm, pp}, 0);
        @(negedge clk);
        chk("pipa", {pm, pp}, sbq.pop_front());
        dat = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle", {pm, pp}, 0);
        check_net();
        sw = 1'b1;
        repeat (2) @(negedge clk);
        sw = 1'b0;
        repeat (4) @(negedge clk);
        sl = (sl + 1) % ML;
        if (sl == 0) begin
            cd_exp++;
            latch_model();
        end
        chk("slot", slot, sl);
        chk("cyc_done", cd_cnt, cd_exp);
    endtask

    initial begin
        set_bias(0, 0, 0);
        for (int i = 0; i < NCHAN; i++) net_m[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_slot", slot, 0);
        chk("rst_pipa", {pm, pp}, 0);
        chk("rst_cd", cd, 0);
        check_net();
        // PIPASW held high through release must not advance the slot
        @(negedge clk) rst_n = 1'b1;
        latch_model();
        repeat (6) @(negedge clk);
        chk("sw_held_slot", slot, 0);
        sw = 1'b0;
        repeat (6) @(negedge clk);
        chk("sw_fall_slot", slot, 0);
        chk("sw_held_cd", cd_cnt, 0);
        // zero bias: p,p,p,m,m,m twice
        repeat (12) pulse();
        // +2 / +6 / -9 (clamped); takes effect only at the next wrap
        set_bias(2, 6, -9);
        repeat (6) pulse();
        for (int i = 0; i < NCHAN; i++) net_m[i] = 0;
`ifdef PIPA_SPOOF_NETCNT_EN
        for (int i = 0; i < NCHAN; i++) net_m[i] = int'($signed(net[i*16 +: 16]));
`endif
        repeat (18) pulse();
        // mid-cycle change at slot 2, odd biases floor
        repeat (2) pulse();
        set_bias(1, -1, 3);
        repeat (4) pulse();
        repeat (6) pulse();
        // reset mid-cycle at slot 4
        repeat (4) pulse();
        @(negedge clk) dat = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_pipa", {pm, pp}, exp_vec());
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pipa", {pm, pp}, 0);
        chk("async_rst_slot", slot, 0);
        dat = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        sl = 0;
        latch_model();
        for (int i = 0; i < NCHAN; i++) net_m[i] = 0;
        repeat (3) @(negedge clk);
        pulse();
        chk("post_rst_slot", slot, 1);
        repeat (5) pulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
